// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_sequencer
// Multi-cycle restoring divider. A start request accepted in IDLE captures the
// operands. LOAD prepares the working registers, SHIFT performs one
// shift-subtract step per clock under an iteration down-counter, and DONE
// publishes quotient/remainder. A one-cycle done pulse follows DONE.
//
// Optional feature macro: SIGNED_DIV_EN
//   defined   : two's-complement operands, quotient truncates toward zero,
//               remainder takes the sign of the dividend
//   undefined : purely unsigned, no sign logic is built
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   start        in   1   request, honoured only in IDLE
//   dividend     in   DW  numerator, captured when start is accepted
//   divisor      in   DW  denominator, captured when start is accepted
//   quotient     out  DW  result, held until the next completion
//   remainder    out  DW  result, held until the next completion
//   busy         out  1   operation in progress, through the done cycle
//   done         out  1   one-cycle completion pulse
//   div_by_zero  out  1   divisor was zero, held with the results
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [DW-1:0] ZERO     = {DW{1'b0}};
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic [DW-1:0] dvd_in_r;     // raw operands as captured on acceptance
    logic [DW-1:0] dvs_in_r;
    logic [DW-1:0] dvs_r;        // divisor magnitude used by the iteration
    logic [DW-1:0] rem_r;        // partial remainder
    logic [DW-1:0] q_r;          // shifts dividend out, quotient bits in
    logic [CW-1:0] cnt_r;

    logic          start_ok_s;
    logic          dvs_zero_s;
    logic [DW:0]   shifted_s;
    logic [DW:0]   trial_s;
    logic [DW-1:0] rem_step_s;
    logic [DW-1:0] q_step_s;
    logic [DW-1:0] dvd_mag_s;
    logic [DW-1:0] dvs_mag_s;
    logic [DW-1:0] q_fin_s;
    logic [DW-1:0] r_fin_s;

`ifdef SIGNED_DIV_EN
    localparam logic [DW-1:0] ONE = DW'(1'b1);

    // Two's-complement negation
    function automatic logic [DW-1:0] neg_f(input logic [DW-1:0] v);
        return (~v) + ONE;
    endfunction

    // Magnitude; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude for the iteration
    function automatic logic [DW-1:0] mag_f(input logic [DW-1:0] v);
        logic [DW-1:0] m;
        if (v[DW-1]) begin
            m = neg_f(v);
        end else begin
            m = v;
        end
        return m;
    endfunction
`endif

    // The cycle carrying the done pulse still belongs to the finishing
    // operation, so a request seen then is dropped rather than accepted.
    assign start_ok_s = start & ~done;
    assign dvs_zero_s = (dvs_in_r == ZERO);

    // One restoring step: the sign bit of the DW+1 bit trial decides restore
    always_comb begin
        shifted_s = {rem_r, q_r[DW-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (trial_s[DW]) begin
            rem_step_s = shifted_s[DW-1:0];
        end else begin
            rem_step_s = trial_s[DW-1:0];
        end
        q_step_s = {q_r[DW-2:0], ~trial_s[DW]};
    end

    // Operand preparation and final sign correction
    always_comb begin
`ifdef SIGNED_DIV_EN
        dvd_mag_s = mag_f(dvd_in_r);
        dvs_mag_s = mag_f(dvs_in_r);
        if (dvd_in_r[DW-1] ^ dvs_in_r[DW-1]) begin
            q_fin_s = neg_f(q_r);
        end else begin
            q_fin_s = q_r;
        end
        if (dvd_in_r[DW-1]) begin
            r_fin_s = neg_f(rem_r);
        end else begin
            r_fin_s = rem_r;
        end
`else
        dvd_mag_s = dvd_in_r;
        dvs_mag_s = dvs_in_r;
        q_fin_s   = q_r;
        r_fin_s   = rem_r;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (dvs_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_in_r <= ZERO;
            dvs_in_r <= ZERO;
            dvs_r    <= ZERO;
            rem_r    <= ZERO;
            q_r      <= ZERO;
            cnt_r    <= CNT_LAST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        dvd_in_r <= dividend;
                        dvs_in_r <= divisor;
                    end
                end
                ST_LOAD: begin
                    cnt_r <= CNT_LAST;
                    rem_r <= ZERO;
                    q_r   <= dvd_mag_s;
                    dvs_r <= dvs_mag_s;
                end
                ST_SHIFT: begin
                    rem_r <= rem_step_s;
                    q_r   <= q_step_s;
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs; results change only when leaving DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient    <= ZERO;
            remainder   <= ZERO;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_r != ST_IDLE);
            done <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                if (dvs_zero_s) begin
                    quotient    <= ALL_ONES;
                    remainder   <= dvd_in_r;
                    div_by_zero <= 1'b1;
                end else begin
                    quotient    <= q_fin_s;
                    remainder   <= r_fin_s;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for div_sequencer (DW=16). Expected results are queued
// when a request is driven and popped when the done pulse appears.
module tb_div_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    div_sequencer #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [DW-1:0] q, input logic [DW-1:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    // Reference division
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        sa  = 0;
        sbv = 0;
        if (b == 16'h0000) begin
            e = mk(16'hFFFF, a, 1'b1);
        end else begin
`ifdef SIGNED_DIV_EN
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            e = mk(DW'(sa / sbv), DW'(sa % sbv), 1'b0);
`else
            sa  = int'(a);
            sbv = int'(b);
            e = mk(DW'(sa / sbv), DW'(sa % sbv), 1'b0);
`endif
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle; returns #1 after the accepting edge
    task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b, input exp_t e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    // Count cycles after acceptance until done (bounded)
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic sb_pop(output exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        if (ok) e = sb_q.pop_front();
        else    e = mk(16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
        #3;
        n_cmp++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got q=%h r=%h b=%b d=%b z=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc; exp_t e; bit ok;
        launch(16'd100, 16'd7, mk(16'd14, 16'd2, 1'b0));
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 18) begin n_bad++; $display("FAIL basic_latency: got %0d want 18", lat); end
        n_cmp++;
        if (bc !== 18) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 18", bc); end
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL basic_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        tick();
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_pulse_end: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_extremes();
        int lat, bc; exp_t e; bit ok;
        launch(16'hFFFF, 16'h0001, mk(16'hFFFF, 16'h0000, 1'b0));
        wait_done(lat, bc);
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || lat !== 18 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL max_by_one: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=18",
                     quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
        end
        tick();
        launch(16'd5, 16'd9, mk(16'd0, 16'd5, 1'b0));
        wait_done(lat, bc);
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL small_by_big: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        tick(); tick(); tick();
        n_cmp++;
        if ({quotient, remainder} !== {16'd0, 16'd5}) begin
            n_bad++;
            $display("FAIL result_hold: got q=%h r=%h want q=0000 r=0005", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; exp_t e; bit ok;
        launch(16'd1234, 16'd0, mk(16'hFFFF, 16'd1234, 1'b1));
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 2 || bc !== 2) begin
            n_bad++;
            $display("FAIL dbz_latency: got lat=%0d busy=%0d want 2 2", lat, bc);
        end
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL dbz_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        tick();
        launch(16'd10, 16'd3, mk(16'd3, 16'd1, 1'b0));
        wait_done(lat, bc);
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL dbz_clear: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int lat, bc, dones, dcyc; exp_t e; bit ok;
        dones = 0;
        dcyc  = -1;
        launch(16'd1000, 16'd13, mk(16'd76, 16'd12, 1'b0));
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (done) begin
                dones++;
                dcyc = k;
                sb_pop(e, ok);
                n_cmp++;
                if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                    n_bad++;
                    $display("FAIL ignore_result: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                             quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
                end
            end
            if (k == 3) begin
                start = 1'b1; dividend = 16'd7; divisor = 16'd1;
            end else if (k == 4) begin
                start = 1'b0;
            end else if (k == 18) begin
                start = 1'b1; dividend = 16'd999; divisor = 16'd2;
            end else if (k == 19) begin
                start = 1'b1; dividend = 16'd21; divisor = 16'd4;
                sb_q.push_back(mk(16'd5, 16'd1, 1'b0));
            end
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (dones !== 1 || dcyc !== 18) begin
            n_bad++;
            $display("FAIL ignore_single_done: got %0d dones at %0d want 1 at 18", dones, dcyc);
        end
        wait_done(lat, bc);
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || lat !== 18 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL accept_after_done: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=18",
                     quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc; exp_t e; bit ok;
        dividend = 16'd60000; divisor = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got q=%h r=%h b=%b d=%b z=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        launch(16'd50, 16'd5, mk(16'd10, 16'd0, 1'b0));
        wait_done(lat, bc);
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || lat !== 18 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=18",
                     quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc, want_lat; exp_t e; bit ok;
        logic [DW-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin a = 16'hFFFF; b = 16'hFFFF; end
                1: begin a = 16'h0000; b = 16'h0005; end
                2: begin a = 16'h0003; b = 16'hFFFF; end
                3: begin a = 16'hABCD; b = 16'h0000; end
                default: begin a = DW'($urandom); b = DW'($urandom_range(1, 400)); end
            endcase
            want_lat = (b == 16'h0000) ? 2 : 18;
            launch(a, b, model(a, b));
            wait_done(lat, bc);
            sb_pop(e, ok);
            n_cmp++;
            if (!ok || lat !== want_lat || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL b2b_%0d: %h/%h got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, a, b, quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz, want_lat);
            end
            tick();
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int lat, bc; exp_t e; bit ok;
        logic [DW-1:0] av[4];
        logic [DW-1:0] bv[4];
        exp_t          ev[4];
        av[0] = 16'hFFF9; bv[0] = 16'h0002; ev[0] = mk(16'hFFFD, 16'hFFFF, 1'b0);
        av[1] = 16'h8000; bv[1] = 16'hFFFF; ev[1] = mk(16'h8000, 16'h0000, 1'b0);
        av[2] = 16'h0007; bv[2] = 16'hFFFE; ev[2] = mk(16'hFFFD, 16'h0001, 1'b0);
        av[3] = 16'hFFF8; bv[3] = 16'h0000; ev[3] = mk(16'hFFFF, 16'hFFF8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            launch(av[i], bv[i], ev[i]);
            wait_done(lat, bc);
            sb_pop(e, ok);
            n_cmp++;
            if (!ok || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_bad++;
                $display("FAIL signed_%0d: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
